// File: rtl/qsys_epcs_nios2_div_pkg.sv
// Shared types and helpers for the Nios II div/divu cell.
// States, default width, divide-by-zero quotient, magnitude helper.
package qsys_epcs_nios2_div_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [DATA_W_DEF-1:0] DIV0_QUOT = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX
  } div_state_e;

  // Magnitude of a full-width value; sign bit is the MSB.
  function automatic logic [DATA_W_DEF-1:0] abs_val(
    input logic [DATA_W_DEF-1:0] value,
    input logic                  is_signed
  );
    if (is_signed && value[DATA_W_DEF-1])
      return -value;
    return value;
  endfunction

endpackage

// File: rtl/qsys_epcs_nios2_div_step.sv
// One restoring-division step: shift in a dividend bit, try subtract.
// The trial difference keeps one extra bit so the borrow is visible.
module qsys_epcs_nios2_div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_rem,
  input  logic              i_dvd_msb,
  input  logic [DATA_W-1:0] i_dvs,
  output logic [DATA_W-1:0] o_next_rem,
  output logic              o_q_bit
);

  logic [DATA_W:0] w_shift;
  logic [DATA_W:0] w_diff;

  assign w_shift = {i_rem, i_dvd_msb};
  assign w_diff  = w_shift - {1'b0, i_dvs};

  always_comb begin
    o_q_bit    = ~w_diff[DATA_W];
    o_next_rem = w_shift[DATA_W-1:0];
    if (!w_diff[DATA_W])
      o_next_rem = w_diff[DATA_W-1:0];
  end

endmodule

// File: rtl/qsys_epcs_nios2_div_cell.sv
// Iterative radix-2 restoring divider for Nios II div/divu.
// QSYS_EPCS_NIOS2_DIV_EARLY_OUT_EN skips ITER for trivial quotients.
module qsys_epcs_nios2_div_cell
  import qsys_epcs_nios2_div_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              A_div_start,
  input  logic              A_div_signed,
  input  logic [DATA_W-1:0] A_div_src1,
  input  logic [DATA_W-1:0] A_div_src2,
  output logic              A_div_busy,
  output logic              A_div_done,
  output logic [DATA_W-1:0] A_div_quotient,
  output logic [DATA_W-1:0] A_div_remainder
);

  localparam int SH = DATA_W_DEF - DATA_W;

  div_state_e r_state;
  div_state_e w_state_nxt;

  logic [DATA_W-1:0] r_src1;
  logic [DATA_W-1:0] r_src2;
  logic              r_signed;
  logic [DATA_W-1:0] r_dvd;
  logic [DATA_W-1:0] r_dvs;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_quo;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_qneg;
  logic              r_rneg;
  logic              r_div0;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] r_quot_o;
  logic [DATA_W-1:0] r_rem_o;

  logic [DATA_W-1:0] w_abs1;
  logic [DATA_W-1:0] w_abs2;
  logic              w_div0;
  logic              w_early;
  logic              w_start_ok;
  logic [DATA_W-1:0] w_next_rem;
  logic              w_q_bit;

  // Left-align so the package helper sees the sign in its MSB.
  function automatic logic [DATA_W-1:0] mag(
    input logic [DATA_W-1:0] v,
    input logic              s
  );
    logic [DATA_W_DEF-1:0] w;
    w = DATA_W_DEF'(v) << SH;
    w = abs_val(w, s);
    return DATA_W'(w >> SH);
  endfunction

  assign w_abs1     = mag(r_src1, r_signed);
  assign w_abs2     = mag(r_src2, r_signed);
  assign w_div0     = (r_src2 == '0);
  assign w_start_ok = (r_state == S_IDLE) && !r_done && A_div_start;

`ifdef QSYS_EPCS_NIOS2_DIV_EARLY_OUT_EN
  assign w_early = w_div0 || (w_abs2 > w_abs1);
`else
  assign w_early = 1'b0;
`endif

  qsys_epcs_nios2_div_step #(
    .DATA_W(DATA_W)
  ) u_step (
    .i_rem     (r_rem),
    .i_dvd_msb (r_dvd[DATA_W-1]),
    .i_dvs     (r_dvs),
    .o_next_rem(w_next_rem),
    .o_q_bit   (w_q_bit)
  );

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start_ok) w_state_nxt = S_PREP;
      S_PREP: w_state_nxt = w_early ? S_FIX : S_ITER;
      S_ITER: if (r_cnt == '0) w_state_nxt = S_FIX;
      S_FIX:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_src1   <= '0;
      r_src2   <= '0;
      r_signed <= 1'b0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_cnt    <= '0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_div0   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_quot_o <= '0;
      r_rem_o  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_src1   <= A_div_src1;
            r_src2   <= A_div_src2;
            r_signed <= A_div_signed;
            r_busy   <= 1'b1;
          end
        end
        S_PREP: begin
          r_dvd  <= w_abs1;
          r_dvs  <= w_abs2;
          r_rem  <= w_early ? w_abs1 : '0;
          r_quo  <= '0;
          r_cnt  <= CNT_W'(DATA_W - 1);
          r_div0 <= w_div0;
          r_qneg <= r_signed &&
                    (r_src1[DATA_W-1] ^ r_src2[DATA_W-1]);
          r_rneg <= r_signed && r_src1[DATA_W-1];
        end
        S_ITER: begin
          r_rem <= w_next_rem;
          r_dvd <= {r_dvd[DATA_W-2:0], 1'b0};
          r_quo <= {r_quo[DATA_W-2:0], w_q_bit};
          r_cnt <= r_cnt - 1'b1;
        end
        S_FIX: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          if (r_div0) begin
            r_quot_o <= DIV0_QUOT[DATA_W-1:0];
            r_rem_o  <= r_src1;
          end else begin
            r_quot_o <= r_qneg ? -r_quo : r_quo;
            r_rem_o  <= r_rneg ? -r_rem : r_rem;
          end
        end
        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign A_div_busy      = r_busy;
  assign A_div_done      = r_done;
  assign A_div_quotient  = r_quot_o;
  assign A_div_remainder = r_rem_o;

endmodule

// File: tb/tb_qsys_epcs_nios2_div_cell.sv
// Bench for qsys_epcs_nios2_div_cell: cycle model plus directed vectors.
// The model derives results from plain signed/unsigned arithmetic.
module tb_qsys_epcs_nios2_div_cell;

`ifdef QSYS_EPCS_NIOS2_DIV_EARLY_OUT_EN
  localparam int L_SHORT = 3;
`else
  localparam int L_SHORT = 35;
`endif
  localparam int L_FULL = 35;

  logic        clk;
  logic        reset;
  logic        A_div_start;
  logic        A_div_signed;
  logic [31:0] A_div_src1;
  logic [31:0] A_div_src2;
  logic        A_div_busy;
  logic        A_div_done;
  logic [31:0] A_div_quotient;
  logic [31:0] A_div_remainder;

  qsys_epcs_nios2_div_cell dut (
    .clk            (clk),
    .reset          (reset),
    .A_div_start    (A_div_start),
    .A_div_signed   (A_div_signed),
    .A_div_src1     (A_div_src1),
    .A_div_src2     (A_div_src2),
    .A_div_busy     (A_div_busy),
    .A_div_done     (A_div_done),
    .A_div_quotient (A_div_quotient),
    .A_div_remainder(A_div_remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int e = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference results straight from integer division semantics.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  input logic s, output logic [31:0] q,
                                  output logic [31:0] r);
    longint sa, sb, qq, rr;
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (s) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      qq = sa / sb;
      rr = sa % sb;
      q = qq[31:0];
      r = rr[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b,
                                 input logic s);
    logic [31:0] ua, ub;
    ua = (s && a[31]) ? -a : a;
    ub = (s && b[31]) ? -b : b;
    return (b == 0 || ub > ua) ? L_SHORT : L_FULL;
  endfunction

  // Cycle model: values expected during the cycle after edge e.
  bit          m_act = 0, m_busy = 0, m_done = 0, acc;
  int          m_a = 0, m_lat = 0;
  logic [31:0] m_q = 0, m_r = 0, m_pq = 0, m_pr = 0;

  always @(posedge clk) begin
    e = e + 1;
    if (reset) begin
      m_act = 0; m_busy = 0; m_done = 0;
      m_q = 0; m_r = 0;
    end else begin
      acc = A_div_start && !m_act && !m_done;
      m_done = m_act && (e == m_a + m_lat - 1);
      if (m_done) begin
        m_q = m_pq; m_r = m_pr; m_act = 0;
      end
      if (acc) begin
        m_act = 1;
        m_a = e;
        ref_div(A_div_src1, A_div_src2, A_div_signed, m_pq, m_pr);
        m_lat = ref_lat(A_div_src1, A_div_src2, A_div_signed);
      end
      m_busy = m_act && (e <= m_a + m_lat - 2);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model busy", 32'(A_div_busy), 32'(m_busy));
      chk("model done", 32'(A_div_done), 32'(m_done));
      chk("model quot", A_div_quotient, m_q);
      chk("model rem", A_div_remainder, m_r);
    end
  end

  task automatic wait_done(output bit seen);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (A_div_done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic s, output int e0);
    @(negedge clk);
    A_div_start  = 1'b1;
    A_div_src1   = a;
    A_div_src2   = b;
    A_div_signed = s;
    e0 = e;
    @(negedge clk);
    A_div_start = 1'b0;
  endtask

  task automatic finish_op(input string nm, input int e0,
                           input logic [31:0] eq, input logic [31:0] er,
                           input int elat);
    bit seen;
    wait_done(seen);
    if (!seen) begin
      chk({nm, " timeout"}, 32'd0, 32'd1);
    end else begin
      chk({nm, " quot"}, A_div_quotient, eq);
      chk({nm, " rem"}, A_div_remainder, er);
      chk({nm, " lat"}, 32'(e - e0), 32'(elat));
    end
  endtask

  task automatic do_op(input string nm, input logic [31:0] a,
                       input logic [31:0] b, input logic s,
                       input logic [31:0] eq, input logic [31:0] er,
                       input int elat);
    int e0;
    issue(a, b, s, e0);
    finish_op(nm, e0, eq, er, elat);
  endtask

  initial begin
    int e0;
    bit seen;
    reset = 1'b1;
    A_div_start = 1'b0;
    A_div_signed = 1'b0;
    A_div_src1 = '0;
    A_div_src2 = '0;
    @(negedge clk);
    chk_en = 1;
    chk("reset busy", 32'(A_div_busy), 32'd0);
    chk("reset done", 32'(A_div_done), 32'd0);
    chk("reset quot", A_div_quotient, 32'd0);
    chk("reset rem", A_div_remainder, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    do_op("divu 100/7", 100, 7, 0, 14, 2, L_FULL);
    do_op("div -100/7", 32'hFFFFFF9C, 7, 1,
          32'hFFFFFFF2, 32'hFFFFFFFE, L_FULL);
    do_op("div 100/-7", 100, 32'hFFFFFFF9, 1, 32'hFFFFFFF2, 2, L_FULL);
    do_op("div ovf", 32'h80000000, 32'hFFFFFFFF, 1,
          32'h80000000, 0, L_FULL);
    do_op("divu max/1", 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 0, L_FULL);
    do_op("divu by 0", 32'h12345678, 0, 0,
          32'hFFFFFFFF, 32'h12345678, L_SHORT);
    do_op("div by 0", 32'h87654321, 0, 1,
          32'hFFFFFFFF, 32'h87654321, L_SHORT);
    do_op("div 7/-100", 7, 32'hFFFFFF9C, 1, 0, 7, L_SHORT);
    do_op("div -7/100", 32'hFFFFFFF9, 100, 1, 0, 32'hFFFFFFF9, L_SHORT);
    do_op("divu max/16", 32'hFFFFFFFF, 16, 0, 32'h0FFFFFFF, 15, L_FULL);
    do_op("div -1/16", 32'hFFFFFFFF, 16, 1, 0, 32'hFFFFFFFF, L_SHORT);
    do_op("div min/2", 32'h80000000, 2, 1, 32'hC0000000, 0, L_FULL);

    // Start while busy is ignored; start in the done cycle too.
    issue(1000, 10, 0, e0);
    repeat (4) @(negedge clk);
    A_div_start = 1'b1;
    A_div_src1 = 5;
    A_div_src2 = 1;
    @(negedge clk);
    A_div_start = 1'b0;
    finish_op("busy ignore", e0, 100, 0, L_FULL);
    A_div_start = 1'b1;
    A_div_src1 = 81;
    A_div_src2 = 9;
    @(negedge clk);
    e0 = e;
    @(negedge clk);
    A_div_start = 1'b0;
    finish_op("back2back", e0, 9, 0, L_FULL);

    // Reset in the middle of an operation.
    issue(5000, 3, 0, e0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset busy", 32'(A_div_busy), 32'd0);
    chk("midreset done", 32'(A_div_done), 32'd0);
    chk("midreset quot", A_div_quotient, 32'd0);
    chk("midreset rem", A_div_remainder, 32'd0);
    do_op("after reset", 5000, 3, 0, 1666, 2, L_FULL);

    repeat (3) @(negedge clk);
    wait_done(seen);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
